// File: rtl/rf_wb_scheduler.sv
// Register-file write-port owner: arbitrates pipeline (P) and long-latency (L) writebacks,
// keeps a busy scoreboard for outstanding long-latency results and raises decode stalls.
module rf_wb_scheduler #(
    parameter int N          = 32,
    parameter int M          = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         p_valid,
    output logic         p_ready,
    input  logic [4:0]   p_rd,
    input  logic [N-1:0] p_data,
    input  logic         l_valid,
    output logic         l_ready,
    input  logic [4:0]   l_rd,
    input  logic [N-1:0] l_data,
    input  logic         dec_valid,
    input  logic [4:0]   dec_rs1,
    input  logic [4:0]   dec_rs2,
    input  logic [4:0]   dec_rd,
    input  logic         dec_use_rs1,
    input  logic         dec_use_rs2,
    input  logic         dec_rd_we,
    input  logic         dec_long,
    output logic         stall,
    output logic         w_enb,
    output logic [4:0]   w_rd,
    output logic [N-1:0] w_data,
    output logic [5:0]   busy_cnt,
    output logic         err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [SW-1:0] starve_cnt_reg, starve_cnt_next;
    logic [M-1:0]  busy_reg, busy_next;
    logic [5:0]    busy_cnt_reg, busy_cnt_next;
    logic          err_reg, err_next;
    logic          w_enb_reg, w_enb_next;
    logic [4:0]    w_rd_reg, w_rd_next;
    logic [N-1:0]  w_data_reg, w_data_next;

    logic force_l;
    logic p_hs, l_hs;
    logic set_en, clr_en;
    logic cnt_inc, cnt_dec;
    logic hit_rs1, hit_rs2, hit_rd;

    // Arbitration: P wins by default; L is forced through once it has waited STARVE_MAX cycles.
    assign force_l = (starve_cnt_reg == SW'(STARVE_MAX));
    assign l_ready = !p_valid || force_l;
    assign p_ready = !(l_valid && force_l);
    assign p_hs    = p_valid && p_ready;
    assign l_hs    = l_valid && l_ready;

    // The in-flight write register counts as a hazard: the register file commits it next edge.
    assign hit_rs1 = (dec_rs1 != 5'd0) && (busy_reg[dec_rs1] || (w_enb_reg && w_rd_reg == dec_rs1));
    assign hit_rs2 = (dec_rs2 != 5'd0) && (busy_reg[dec_rs2] || (w_enb_reg && w_rd_reg == dec_rs2));
    assign hit_rd  = (dec_rd  != 5'd0) && (busy_reg[dec_rd]  || (w_enb_reg && w_rd_reg == dec_rd));
    assign stall   = dec_valid && ((dec_use_rs1 && hit_rs1) || (dec_use_rs2 && hit_rs2) ||
                                   (dec_rd_we && hit_rd));

    assign set_en = dec_valid && dec_long && dec_rd_we && !stall && (dec_rd != 5'd0);
    assign clr_en = l_hs && (l_rd != 5'd0);

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_busy
            assign busy_next[gi] = (set_en && dec_rd == 5'(gi)) ? 1'b1 :
                                   (clr_en && l_rd == 5'(gi))   ? 1'b0 : busy_reg[gi];
        end
    endgenerate

    // Count only real transitions so busy_cnt always equals the number of set bits.
    assign cnt_inc = set_en && !busy_reg[dec_rd];
    assign cnt_dec = clr_en && busy_reg[l_rd] && !(set_en && dec_rd == l_rd);

    always_comb begin
        busy_cnt_next = busy_cnt_reg;
        if (cnt_inc && !cnt_dec)
            busy_cnt_next = busy_cnt_reg + 6'd1;
        else if (cnt_dec && !cnt_inc)
            busy_cnt_next = busy_cnt_reg - 6'd1;
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (l_hs || !l_valid)
            starve_cnt_next = '0;
        else if (starve_cnt_reg != SW'(STARVE_MAX))
            starve_cnt_next = starve_cnt_reg + SW'(1);
    end

    always_comb begin
        err_next = err_reg;
        if (l_hs && (l_rd != 5'd0) && !busy_reg[l_rd])
            err_next = 1'b1;
        if (p_hs && (p_rd != 5'd0) && busy_reg[p_rd])
            err_next = 1'b1;
    end

    always_comb begin
        w_enb_next  = 1'b0;
        w_rd_next   = w_rd_reg;
        w_data_next = w_data_reg;
        if (p_hs && p_rd != 5'd0) begin
            w_enb_next  = 1'b1;
            w_rd_next   = p_rd;
            w_data_next = p_data;
        end else if (l_hs && l_rd != 5'd0) begin
            w_enb_next  = 1'b1;
            w_rd_next   = l_rd;
            w_data_next = l_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
            busy_reg       <= '0;
            busy_cnt_reg   <= '0;
            err_reg        <= 1'b0;
            w_enb_reg      <= 1'b0;
            w_rd_reg       <= '0;
            w_data_reg     <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            busy_reg       <= busy_next;
            busy_cnt_reg   <= busy_cnt_next;
            err_reg        <= err_next;
            w_enb_reg      <= w_enb_next;
            w_rd_reg       <= w_rd_next;
            w_data_reg     <= w_data_next;
        end
    end

    assign w_enb    = w_enb_reg;
    assign w_rd     = w_rd_reg;
    assign w_data   = w_data_reg;
    assign busy_cnt = busy_cnt_reg;
    assign err      = err_reg;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: hand-computed expectations for arbitration,
// scoreboard, hazard stall, error flag and reset behaviour.
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        p_valid, p_ready;
    logic [4:0]  p_rd;
    logic [31:0] p_data;
    logic        l_valid, l_ready;
    logic [4:0]  l_rd;
    logic [31:0] l_data;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic        dec_use_rs1, dec_use_rs2, dec_rd_we, dec_long;
    logic        stall, w_enb;
    logic [4:0]  w_rd;
    logic [31:0] w_data;
    logic [5:0]  busy_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler #(.N(32), .M(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_ready(p_ready), .p_rd(p_rd), .p_data(p_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd_we(dec_rd_we),
        .dec_long(dec_long), .stall(stall),
        .w_enb(w_enb), .w_rd(w_rd), .w_data(w_data), .busy_cnt(busy_cnt), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; registered outputs are stable 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 0; p_rd = 0; p_data = 0;
        l_valid = 0; l_rd = 0; l_data = 0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
        dec_use_rs1 = 0; dec_use_rs2 = 0; dec_rd_we = 0; dec_long = 0;
    endtask

    task automatic issue_long(input logic [4:0] rd);
        dec_valid = 1; dec_long = 1; dec_rd_we = 1; dec_rd = rd;
        dec_use_rs1 = 0; dec_use_rs2 = 0;
        tick();
        dec_valid = 0; dec_long = 0; dec_rd_we = 0; dec_rd = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        $display("txn reset");
        chk("rst_w_enb", 32'(w_enb), 0);
        chk("rst_w_rd", 32'(w_rd), 0);
        chk("rst_w_data", w_data, 0);
        chk("rst_busy_cnt", 32'(busy_cnt), 0);
        chk("rst_err", 32'(err), 0);
        dec_valid = 1; dec_use_rs1 = 1; dec_use_rs2 = 1; dec_rd_we = 1;
        dec_rs1 = 5; dec_rs2 = 7; dec_rd = 3;
        settle();
        chk("rst_stall", 32'(stall), 0);
        idle_inputs();

        // Single pipeline write
        $display("txn p_write rd=5 data=deadbeef");
        p_valid = 1; p_rd = 5; p_data = 32'hDEADBEEF;
        settle();
        chk("p_ready", 32'(p_ready), 1);
        tick();
        p_valid = 0;
        chk("p_w_enb", 32'(w_enb), 1);
        chk("p_w_rd", 32'(w_rd), 5);
        chk("p_w_data", w_data, 32'hDEADBEEF);
        dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5;
        settle();
        chk("inflight_stall", 32'(stall), 1);
        tick();
        chk("after_write_stall", 32'(stall), 0);
        chk("after_write_w_enb", 32'(w_enb), 0);
        chk("hold_w_data", w_data, 32'hDEADBEEF);
        idle_inputs();

        // Long-latency scoreboard
        $display("txn long issue rd=7");
        issue_long(7);
        chk("long_busy_cnt", 32'(busy_cnt), 1);
        dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 7;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("busy_stall", 32'(stall), 1);
            tick();
        end
        $display("txn l_return rd=7 data=1234");
        l_valid = 1; l_rd = 7; l_data = 32'h1234;
        settle();
        chk("l_ready", 32'(l_ready), 1);
        chk("l_cycle_stall", 32'(stall), 1);
        tick();
        l_valid = 0;
        chk("l_busy_cnt", 32'(busy_cnt), 0);
        chk("l_w_enb", 32'(w_enb), 1);
        chk("l_w_rd", 32'(w_rd), 7);
        chk("l_w_data", w_data, 32'h1234);
        chk("l_write_stall", 32'(stall), 1);
        tick();
        chk("l_post_stall", 32'(stall), 0);
        chk("l_err", 32'(err), 0);
        idle_inputs();

        // Starvation: P wins 4 cycles, then L is forced through, then P again
        $display("txn starvation");
        p_valid = 1; p_rd = 10; l_valid = 1; l_rd = 0; l_data = 32'hAAAA;
        for (int i = 0; i < 4; i++) begin
            p_data = 32'(i + 100);
            settle();
            chk("starve_p_ready", 32'(p_ready), 1);
            chk("starve_l_ready", 32'(l_ready), 0);
            tick();
            chk("starve_w_data", w_data, 32'(i + 100));
        end
        settle();
        chk("force_p_ready", 32'(p_ready), 0);
        chk("force_l_ready", 32'(l_ready), 1);
        tick();
        chk("force_l_rd0_w_enb", 32'(w_enb), 0);
        settle();
        chk("recover_p_ready", 32'(p_ready), 1);
        chk("recover_l_ready", 32'(l_ready), 0);
        chk("starve_err", 32'(err), 0);
        idle_inputs();
        tick();

        // Boundaries
        $display("txn p_write rd=0");
        p_valid = 1; p_rd = 0; p_data = 32'h55;
        tick();
        p_valid = 0;
        chk("rd0_w_enb", 32'(w_enb), 0);
        chk("rd0_w_rd_hold", 32'(w_rd), 10);
        $display("txn long issue rd=0");
        issue_long(0);
        chk("long_rd0_busy_cnt", 32'(busy_cnt), 0);
        $display("txn l_return non-busy rd=9");
        l_valid = 1; l_rd = 9; l_data = 32'h9;
        tick();
        l_valid = 0;
        chk("nonbusy_err", 32'(err), 1);
        chk("nonbusy_w_rd", 32'(w_rd), 9);
        tick();
        tick();
        chk("sticky_err", 32'(err), 1);

        // Reset mid-operation
        $display("txn three long issues then reset");
        issue_long(1);
        issue_long(2);
        issue_long(3);
        chk("three_busy_cnt", 32'(busy_cnt), 3);
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_busy_cnt", 32'(busy_cnt), 0);
        chk("midrst_w_enb", 32'(w_enb), 0);
        chk("midrst_err", 32'(err), 0);
        dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 2;
        settle();
        chk("midrst_stall", 32'(stall), 0);
        idle_inputs();

        // P write to a register still owned by L
        $display("txn p_write to busy rd=4");
        issue_long(4);
        p_valid = 1; p_rd = 4; p_data = 32'h44;
        tick();
        p_valid = 0;
        chk("p_busy_err", 32'(err), 1);
        chk("p_busy_w_rd", 32'(w_rd), 4);
        chk("p_busy_cnt", 32'(busy_cnt), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Owns the single write port of the register file and tracks its pending destinations.
- Arbitrates register writes between the in-order pipeline writeback (P) and a long-latency unit such as load or mul/div (L).
- Keeps a per-register busy scoreboard for the long-latency results.
- Raises a decode stall on RAW/WAW hazards against pending or in-flight writes.

Parameters:
- N, 32, data width of write data.
- M, 32, number of architectural registers; x0 hardwired zero.
- STARVE_MAX, 4, cycles L may wait while P holds the port before L is forced through.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- p_valid  in  1  pipeline writeback request.
- p_ready  out  1  pipeline request accepted this cycle.
- p_rd  in  5  pipeline destination.
- p_data  in  N  pipeline write data.
- l_valid  in  1  long-latency unit result request.
- l_ready  out  1  long-latency request accepted this cycle.
- l_rd  in  5  long-latency destination.
- l_data  in  N  long-latency write data.
- dec_valid  in  1  decode-stage instruction valid.
- dec_rs1, dec_rs2, dec_rd  in  5 each  decode register indices.
- dec_use_rs1, dec_use_rs2, dec_rd_we  in  1 each  operand/destination in use.
- dec_long  in  1  decode instruction is long-latency (will return on L).
- stall  out  1  hold decode this cycle.
- w_enb  out  1  register file write enable.
- w_rd  out  5  register file write index.
- w_data  out  N  register file write data.
- busy_cnt  out  6  number of busy scoreboard entries.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs and state are synchronous-reset.
  - w_enb=0, w_rd=0, w_data=0, busy[all]=0, busy_cnt=0, err=0, starve_cnt=0.
  - Reset mid-operation drops all pending entries; the L unit is reset by the same rst.
- Arbitration is combinational, from current valids and starve_cnt.
  - force_l = (starve_cnt == STARVE_MAX).
  - l_ready = !p_valid || force_l.
  - p_ready = !(l_valid && force_l).
  - A handshake is valid && ready. At most one handshake per cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) when l_valid && !l_ready.
  - Clears on an L handshake or when l_valid=0.
- Write output register, latency 1:
  - On the edge after a handshake with rd != 0: w_enb=1 and w_rd/w_data come from the granted source.
  - Otherwise w_enb=0, and w_rd/w_data hold their values.
  - An rd=0 handshake is accepted but produces no write.
- Scoreboard set: at the edge when dec_valid && dec_long && dec_rd_we && !stall && dec_rd != 0, busy[dec_rd] is set.
- Scoreboard clear: at the edge of an L handshake, busy[l_rd] is cleared.
  - If the same index is set and cleared in one cycle, set wins.
- err:
  - Set sticky on an L handshake with l_rd != 0 and busy[l_rd]=0.
  - Also set sticky on a P handshake with busy[p_rd]=1 and p_rd != 0.
  - The write still proceeds.
- busy_cnt tracks the scoreboard exactly: +1 on set, -1 on clear, unchanged on both or neither. Range 0..31.
- Hazard check, combinational:
  - hit(r) = (r != 0) && (busy[r] || (w_enb && w_rd == r)).
  - stall = dec_valid && ((dec_use_rs1 && hit(dec_rs1)) || (dec_use_rs2 && hit(dec_rs2)) || (dec_rd_we && hit(dec_rd))).
  - The in-flight output register is included because the register file commits it only at the next edge.
- stall does not depend on p_valid or l_valid, so there is no combinational loop with the requesters.

Test Plan:
- Reset then idle: rst high 2 cycles -> w_enb=0, busy_cnt=0, err=0, stall=0 for any dec inputs.
- Single P write, p_rd=5, p_data=0xDEADBEEF:
  - p_ready=1 -> next cycle w_enb=1, w_rd=5, w_data=0xDEADBEEF.
  - A dec_rs1=5 read that cycle gives stall=1; the cycle after gives stall=0.
- Long-op scoreboard:
  - Issue dec_long with dec_rd=7 -> busy_cnt=1; dec_rs2=7 stalls every cycle.
  - L handshake with l_rd=7, data 0x1234 -> busy_cnt=0, w_rd=7 one cycle later, stall deasserts the cycle after the write.
- Starvation: p_valid and l_valid held high continuously -> p granted 4 consecutive cycles, 5th cycle l_ready=1, p_ready=0, starve_cnt returns to 0.
- Boundaries:
  - P handshake with rd=0 -> no w_enb.
  - dec_long with dec_rd=0 -> busy_cnt stays 0.
  - L return to a non-busy reg 9 -> err=1 and stays 1 until rst.
- Reset mid-operation: three regs busy (busy_cnt=3), assert rst for 1 cycle -> busy_cnt=0, stall=0, w_enb=0 next cycle.
